// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the memory access unit.
//   - mau_state_e : access FSM states (IDLE, REQ, WAIT, DONE)
//   - MAU_AW / MAU_DW / MAU_TIMEOUT : default address width, data width and
//     acknowledge timeout (cycles), the latter only meaningful when the design
//     is built with MAU_TIMEOUT_EN defined.
package mau_pkg;

  localparam int MAU_AW      = 16;
  localparam int MAU_DW      = 16;
  localparam int MAU_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mau_timeout_ctr.sv
// mau_timeout_ctr: counts request cycles that went unacknowledged and flags
// when the current cycle is the last one allowed before giving up.
// Ports:
//   clk     in  clock
//   aclr    in  synchronous active-high reset
//   clr     in  restart count (access is starting)
//   inc     in  one more unacknowledged request cycle
//   expired out this is the TIMEOUT-th unacknowledged cycle
module mau_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic aclr,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Count value held while the TIMEOUT-th ack-less cycle is in progress.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on access start, step on every ack-less request cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (aclr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR register pair plus a four-state FSM that runs one
// memory read or write per mio_en and pulses r on completion.
// Optional feature: define MAU_TIMEOUT_EN to abort accesses that go TIMEOUT
// cycles without mem_ack (r with err=1). Without it the FSM waits forever.
// Ports:
//   clk, aclr          clock, synchronous active-high reset
//   bus_in             processor bus (MAR <- bus_in[AW-1:0], MDR <- bus_in)
//   ld_mar, ld_mdr     register loads, honoured only in IDLE
//   mio_en, r_w        start access (r_w: 1=write, 0=read), IDLE only
//   mar_out, mdr_out   current MAR / MDR
//   r, err             completion pulse and timeout flag
//   mem_req, mem_we    memory request and write strobe
//   mem_addr, mem_wdata  MAR / MDR driven to memory
//   mem_rdata, mem_ack memory read data and completion
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int AW      = MAU_AW,
  parameter int DW      = MAU_DW,
  parameter int TIMEOUT = MAU_TIMEOUT
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic [DW-1:0] bus_in,
  input  logic          ld_mar,
  input  logic          ld_mdr,
  input  logic          mio_en,
  input  logic          r_w,
  output logic [AW-1:0] mar_out,
  output logic [DW-1:0] mdr_out,
  output logic          r,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  mau_state_e    state_q, state_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic          we_q, we_d;
  logic          r_q, r_d;
  logic          err_q, err_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic          expired_s;

`ifdef MAU_TIMEOUT_EN
  logic start_s;
  logic busy_noack_s;

  assign start_s      = (state_q == ST_IDLE) && mio_en;
  assign busy_noack_s = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && !mem_ack;

  mau_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .aclr    (aclr),
    .clr     (start_s),
    .inc     (busy_noack_s),
    .expired (expired_s)
  );
`else
  logic unused_timeout_s;

  assign unused_timeout_s = (TIMEOUT > 0);
  assign expired_s        = 1'b0;
`endif

  // Next-state, register-load and registered-output decode.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_mar) begin
          mar_d = bus_in[AW-1:0];
        end else begin
          mar_d = mar_q;
        end
        if (ld_mdr) begin
          mdr_d = bus_in;
        end else begin
          mdr_d = mdr_q;
        end
        if (mio_en) begin
          we_d    = r_w;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ, ST_WAIT: begin
        // An ack arriving on the limit cycle still completes normally.
        if (mem_ack) begin
          state_d = ST_DONE;
          if (!we_q) begin
            mdr_d = mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
        end else if (expired_s) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs are registered from the state being entered.
    r_d       = (state_d == ST_DONE);
    mem_req_d = (state_d == ST_REQ) || (state_d == ST_WAIT);
    mem_we_d  = mem_req_d && we_d;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q   <= ST_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      we_q      <= 1'b0;
      r_q       <= 1'b0;
      err_q     <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      we_q      <= we_d;
      r_q       <= r_d;
      err_q     <= err_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign r         = r_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;

endmodule
